onehot_scan_decoder: RTL and testbench
======================================

Name: onehot_scan_decoder

Overview:
- Parametrised, registered successor to the team's combinational 3-to-8 decoder: an SEL_W-to-2**SEL_W one-hot decoder with enable.
- Adds an auto-scan mode that walks the active output across all channels with a programmable dwell time, plus a wrap strobe.
- Sits between control logic and multiplexed loads (display digit strobes, channel/row selects).

Parameters:
- SEL_W, 3, width of the binary select; N_OUT = 2**SEL_W outputs (derived localparam, not overridable).
- DWELL_W, 8, width of the dwell-count input and internal dwell counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  block enable; 0 forces all outputs inactive
- mode  input  1  0 = direct decode, 1 = auto scan
- load  input  1  single-cycle strobe: capture sel into the index register
- sel  input  SEL_W  binary channel select, MSB = sel[SEL_W-1]
- dwell  input  DWELL_W  cycles-minus-one each channel stays active in scan mode
- dout  output  N_OUT  one-hot outputs, dout[k]=1 when index==k and block active
- cur_sel  output  SEL_W  current index register
- wrap  output  1  one-cycle pulse when scan advances from N_OUT-1 to 0

Behaviour:
- One clock; reset is synchronous and active-high (rst sampled on rising clk). Reset: state=OFF, idx=0, cnt=0, wrap=0, so dout=0 and cur_sel=0.
- Reset mid-scan has the same effect as power-on reset. Reset has priority over all other inputs.
- State register takes one of OFF, DIRECT or SCAN. Next state is chosen every cycle:
  - en=0 -> OFF
  - en=1, mode=0 -> DIRECT
  - en=1, mode=1 -> SCAN
- dout = (state!=OFF) ? (1<<idx) : 0. It is decoded from registers only, with no combinational path from inputs. Input sampled at edge k is visible on dout after edge k (1-cycle latency).
- cur_sel = idx at all times, including in OFF.
- In OFF (en=0): load ignored, idx held, cnt cleared to 0, wrap=0.
- In DIRECT: load=1 -> idx<=sel. cnt held at 0, wrap=0. sel changes without load have no effect.
- In SCAN, evaluated in priority order:
  - load=1 -> idx<=sel, cnt<=0, wrap<=0.
  - else if cnt>=dwell -> cnt<=0 and idx<=idx+1, wrapping N_OUT-1 -> 0. wrap<=1 only on that wrap.
  - else cnt<=cnt+1, wrap<=0.
- Each channel is therefore active dwell+1 cycles. dwell=0 advances every cycle.
- The ">=" compare makes a live reduction of dwell below the current cnt advance on the next edge; no stall or counter overflow occurs.
- Entering SCAN from DIRECT or OFF: cnt starts from 0 and idx is retained (or sel if load is asserted on the entry cycle).
- Leaving SCAN: cnt cleared and wrap deasserted on the same edge.
- wrap is registered and high for exactly one cycle per full sweep. It never asserts in DIRECT or OFF, or on a load-induced jump to 0.
- All index arithmetic is modulo N_OUT (natural SEL_W-bit rollover). cnt is DWELL_W bits and cannot exceed dwell, so it never overflows.

Decomposition:
- Shared package: state enum {OFF, DIRECT, SCAN} and the mode encodings MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
- One natural sub-module: onehot_dec, a purely combinational SEL_W-to-N_OUT decoder with enable, instantiated for dout.
- The top level holds the state register, idx, cnt and wrap.

Test Plan:
- Reset/enable: rst=1 for 2 cycles with en=1, mode=1 -> dout=8'h00, cur_sel=0, wrap=0. Then en=0 with load=1, sel=5 -> dout stays 8'h00, cur_sel stays 0.
- Direct decode, SEL_W=3: en=1, mode=0, load pulses with sel=0..7 -> dout = 8'h01, 02, 04, ... 80, one cycle after each load. sel changed to 3 without load -> dout unchanged.
- Scan, dwell=2, start idx=0: dout holds each one-hot for 3 cycles, sequence 01,02,...,80,01. wrap is high exactly the cycle dout returns to 8'h01, once per 24 cycles.
- Scan, dwell=0: dout advances every cycle and wrap pulses every 8 cycles. Then dwell drops from 10 to 1 while cnt=6 -> advance on the next edge.
- Load during scan: at idx=6, load=1, sel=2 -> next dout=8'h04, cnt restarts, no wrap pulse. Repeat with sel=0 at idx=7 -> still no wrap.
- Mode/enable interleave: mid-scan at idx=4, en=0 for 3 cycles -> dout=00, cur_sel=4. Re-enable -> dout=8'h10 for a full dwell+1 cycles. Then mode=0 -> dout frozen at the current one-hot and wrap=0.

Source files
------------

// File: rtl/onehot_scan_decoder_pkg.sv
// Shared types and constants for the one-hot scan decoder.
//   state_e     : operating state of the decoder (off, direct decode, auto scan)
//   MODE_DIRECT : value of the mode input selecting direct decode
//   MODE_SCAN   : value of the mode input selecting auto scan
package onehot_scan_decoder_pkg;

  typedef enum logic [1:0] {
    StOff    = 2'd0,
    StDirect = 2'd1,
    StScan   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_scan_decoder_if.sv
// Control/status bundle of the one-hot scan decoder.
//   en      : block enable, 0 forces all outputs inactive
//   mode    : MODE_DIRECT or MODE_SCAN
//   load    : single-cycle strobe capturing sel into the index register
//   sel     : binary channel select
//   dwell   : cycles-minus-one each channel stays active while scanning
//   dout    : one-hot channel outputs
//   cur_sel : current index register
//   wrap    : one-cycle pulse when the scan rolls over from the last channel to 0
// master drives the controls (control logic / testbench); slave is the decoder.
interface onehot_scan_decoder_if #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
);

  logic                    en;
  logic                    mode;
  logic                    load;
  logic [SEL_W-1:0]        sel;
  logic [DWELL_W-1:0]      dwell;
  logic [(1<<SEL_W)-1:0]   dout;
  logic [SEL_W-1:0]        cur_sel;
  logic                    wrap;

  modport master (
    output en, mode, load, sel, dwell,
    input  dout, cur_sel, wrap
  );

  modport slave (
    input  en, mode, load, sel, dwell,
    output dout, cur_sel, wrap
  );

endinterface

// File: rtl/onehot_scan_decoder_onehot_dec.sv
// Purely combinational SEL_W-to-2**SEL_W one-hot decoder with enable.
//   sel  : binary select, MSB = sel[SEL_W-1]
//   en   : 0 forces every output low
//   dout : dout[k] = en && (sel == k)
module onehot_dec #(
  parameter int unsigned SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [(1<<SEL_W)-1:0] dout
);

  localparam int unsigned N_OUT = 1 << SEL_W;

  always_comb begin
    dout = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (en && (sel == SEL_W'(k))) begin
        dout[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot decoder with direct-decode and auto-scan modes.
//   clk : system clock, all state updates on the rising edge
//   rst : synchronous active-high reset, priority over every other input
//   bus : onehot_scan_decoder_if slave (en, mode, load, sel, dwell in;
//         dout, cur_sel, wrap out)
// The state register, index, dwell counter and wrap flag live here; dout is
// decoded from registers only, so inputs reach the outputs one cycle later.
module onehot_scan_decoder
  import onehot_scan_decoder_pkg::*;
#(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  onehot_scan_decoder_if.slave  bus
);

  localparam int unsigned N_OUT = 1 << SEL_W;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
  logic [N_OUT-1:0]   dout_dec;

  // Next state is a pure function of the current en/mode inputs.
  always_comb begin
    state_d = StOff;
    if (bus.en) begin
      state_d = (bus.mode == MODE_SCAN) ? StScan : StDirect;
    end
  end

  // Index / dwell counter / wrap update, keyed on the state being entered.
  // The counter defaults to 0 so that OFF, DIRECT and any entry into SCAN
  // start the dwell from scratch; only a continuing scan counts.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = '0;
    wrap_d = 1'b0;
    unique case (state_d)
      StOff: begin
        // load ignored, index held
      end
      StDirect: begin
        if (bus.load) begin
          idx_d = bus.sel;
        end
      end
      StScan: begin
        if (bus.load) begin
          idx_d = bus.sel;
        end else if (state_q != StScan) begin
          // Entry cycle: keep the index, dwell starts at 0.
        end else if (cnt_q >= bus.dwell) begin
          // ">=" lets a live shrink of dwell below cnt advance immediately.
          idx_d  = idx_q + SEL_W'(1);
          wrap_d = &idx_q;
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: begin
        idx_d = idx_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StOff;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  onehot_dec #(
    .SEL_W(SEL_W)
  ) u_onehot_dec (
    .sel  (idx_q),
    .en   (state_q != StOff),
    .dout (dout_dec)
  );

  assign bus.dout    = dout_dec;
  assign bus.cur_sel = idx_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Bench for onehot_scan_decoder: directed sequences from the test plan followed
// by random traffic; a reference model predicts dout/cur_sel/wrap per cycle into
// a queue and a monitor process compares each cycle's outputs against it.
module tb_onehot_scan_decoder;

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned DWELL_W = 8;
  localparam int unsigned N_OUT   = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  onehot_scan_decoder_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

  onehot_scan_decoder #(
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [N_OUT-1:0] dout;
    logic [SEL_W-1:0] cur_sel;
    logic             wrap;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: channel shown for 'shown' cycles so far; a channel is
  // visible dwell+1 cycles before the scan moves on.
  int m_idx     = 0;
  int m_shown   = 0;
  bit m_active  = 0;
  bit m_scan    = 0;
  bit m_wrap    = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, req);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit m, input bit l,
                      input int s, input int d);
    exp_t x;
    @(negedge clk);
    rst       = r;
    bus.en    = e;
    bus.mode  = m;
    bus.load  = l;
    bus.sel   = SEL_W'(s);
    bus.dwell = DWELL_W'(d);
    m_wrap = 0;
    if (r) begin
      m_idx = 0; m_shown = 0; m_active = 0; m_scan = 0;
    end else if (!e) begin
      m_active = 0; m_scan = 0;
    end else if (l) begin
      m_idx = s % N_OUT; m_active = 1; m_scan = m; m_shown = 1;
    end else if (!m) begin
      m_active = 1; m_scan = 0;
    end else if (!m_scan) begin
      m_active = 1; m_scan = 1; m_shown = 1;
    end else if (m_shown >= d + 1) begin
      m_idx   = (m_idx + 1) % N_OUT;
      m_shown = 1;
      m_wrap  = (m_idx == 0);
    end else begin
      m_shown++;
    end
    x.dout    = m_active ? N_OUT'(1 << m_idx) : '0;
    x.cur_sel = SEL_W'(m_idx);
    x.wrap    = m_wrap;
    exp_q.push_back(x);
  endtask

  // Monitor: one expected entry per clock once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dout",    int'(bus.dout),    int'(e.dout));
        check("cur_sel", int'(bus.cur_sel), int'(e.cur_sel));
        check("wrap",    int'(bus.wrap),    int'(e.wrap));
      end
    end
  end

  initial begin
    int dw;
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.mode  = 1'b0;
    bus.load  = 1'b0;
    bus.sel   = '0;
    bus.dwell = '0;

    // Reset with scan requested, then disabled load attempt.
    step(1, 1, 1, 0, 0, 2);
    step(1, 1, 1, 0, 0, 2);
    step(0, 0, 0, 1, 5, 2);
    step(0, 0, 0, 0, 5, 2);

    // Direct decode of every channel, then sel change without load.
    for (int s = 0; s < 8; s++) begin
      step(0, 1, 0, 1, s, 2);
      step(0, 1, 0, 0, s, 2);
    end
    step(0, 1, 0, 0, 3, 2);
    step(0, 1, 0, 0, 3, 2);

    // Scan dwell=2 from idx 0: two full sweeps.
    step(0, 1, 1, 1, 0, 2);
    for (int i = 0; i < 50; i++) step(0, 1, 1, 0, 0, 2);

    // Scan dwell=0, then dwell shrinks from 10 to 1 with cnt at 6.
    for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 10);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, 10);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 1);

    // Loads during scan, including a jump to 0 from the last channel.
    step(0, 1, 1, 1, 6, 3);
    step(0, 1, 1, 0, 0, 3);
    step(0, 1, 1, 1, 2, 3);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 3);
    step(0, 1, 1, 1, 7, 3);
    step(0, 1, 1, 1, 0, 3);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 3);

    // Disable mid-scan at idx 4, re-enable, then freeze in direct mode.
    step(0, 1, 1, 1, 4, 3);
    step(0, 1, 1, 0, 0, 3);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 3);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, 3);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 3);

    // Random traffic.
    dw = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) dw = int'($urandom_range(0, 6));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           int'($urandom_range(0, 7)), dw);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
